uart_rx_fsm: RTL and testbench
==============================

# uart_rx_fsm

Frame-sequencing controller for the UART receiver. Detects the start condition on the serial line, enables the edge/bit counter, and pulses the per-bit enables for the data sampler, deserializer, and start/parity/stop checkers. Raises `data_valid` for one cycle per error-free frame. It sits between the RX line and the counter/checker datapath inside the UART RX top.

## Interface
Parameters:
- `DATA_W`, default 8: data bits per frame.
- `PRESC_W`, default 6: prescale input width.

Ports:
- `clk`, in, 1: receiver oversampling clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `rx_in`, in, 1: serial line, already synchronized; idle high.
- `par_en`, in, 1: parity bit present in the frame.
- `prescale`, in, PRESC_W: oversampling ratio P. Legal values are 8, 16 and 32.
- `bit_cnt`, in, 4: bit index from the edge/bit counter.
- `edge_cnt`, in, 5: edge index within the current bit (0..P-1).
- `strt_glitch`, in, 1: start checker result, valid while `strt_chk_en` is high.
- `par_err`, in, 1: parity checker result, valid while `par_chk_en` is high.
- `stp_err`, in, 1: stop checker result, valid while `stp_chk_en` is high.
- `cnt_en`, out, 1: edge/bit counter enable. While low, the counter holds 0.
- `dat_samp_en`, out, 1: data sampler enable.
- `deser_en`, out, 1: deserializer shift strobe.
- `strt_chk_en`, out, 1: start checker strobe.
- `par_chk_en`, out, 1: parity checker strobe.
- `stp_chk_en`, out, 1: stop checker strobe.
- `data_valid`, out, 1: one-cycle pulse marking a good frame.

## Operation
- The state register holds one of six states: IDLE, START, DATA, PARITY, STOP, VALID.
- `last_edge` is defined as `edge_cnt == prescale-1`. The compare is done at PRESC_W+1 bits with no truncation.
- Bit indices: 0 is the start bit, 1..DATA_W are data, DATA_W+1 is parity when present, and the stop bit follows.
- IDLE → START when `rx_in`=0. `par_en` is latched into `par_en_q` on this transition. Mid-frame changes to `par_en` have no effect.
- START: at `last_edge`, `strt_chk_en`=1. If `strt_glitch`=1 → IDLE, otherwise → DATA.
- DATA: at `last_edge`, `deser_en`=1. At `last_edge` with `bit_cnt`==DATA_W → PARITY if `par_en_q`, otherwise → STOP.
- PARITY: at `last_edge`, `par_chk_en`=1. If `par_err`=1 → IDLE (frame dropped), otherwise → STOP.
- STOP: at `last_edge`, `stp_chk_en`=1. If `stp_err`=1 → IDLE, otherwise → VALID.
- VALID: `data_valid`=1 for exactly this one cycle. Next state is START if `rx_in`=0 (back-to-back frame), otherwise IDLE.
- `cnt_en` = (state ∈ {START, DATA, PARITY, STOP}).
- `dat_samp_en` = `cnt_en`.
- All strobes are combinational decodes of state, `last_edge` and the error inputs (Mealy). No strobe is asserted outside its own state.
- Simultaneous events: the error input always takes priority over the advance at `last_edge`.
- A low `rx_in` during VALID is the only allowed START entry other than from IDLE.

## Timing
- Reset values: state=IDLE, `par_en_q`=0, and every output 0. Reset asserted mid-frame returns the block to IDLE asynchronously, and the counter clears through `cnt_en`=0.
- Start detection: `rx_in` falling at cycle n means state=START and `cnt_en`=1 from cycle n+1. The counter's edge 0 is cycle n+1.
- Each bit lasts exactly P cycles while `cnt_en`=1.
- Frame with no parity: START at n+1, `data_valid` at cycle n+1+(DATA_W+2)·P. With parity, add P.
- Between frames `cnt_en` is low for at least one cycle (VALID or IDLE), which guarantees the counter reset.

## Configuration
- `UART_RX_FRAME_ERR_EN`
  - Defined: adds output `frame_err` (1 bit), a one-cycle pulse on any start-glitch, parity-error or stop-error abort, coincident with the strobe that detected it. Reset value 0.
  - Undefined: the port is absent and abort behaviour is otherwise identical.

## Structure
- Package `uart_rx_pkg` holds:
  - the state enum `rx_state_t`;
  - constants `START_BIT_IDX`=0 and `LAST_DATA_IDX`=DATA_W;
  - legal prescale constants `PRESC_8`, `PRESC_16`, `PRESC_32`.
- No sub-module. The FSM is a single module, instanced beside the edge/bit counter in the RX top.

## Test plan
- P=8, no parity, byte 0xA5 with clean stop → `deser_en` pulses 8 times. `data_valid` at START+80 cycles. No other check strobe is high except `strt_chk_en` once and `stp_chk_en` once.
- P=16, `par_en`=1, even parity correct → `par_chk_en` once at START+159. `data_valid` at START+176.
- P=8, `strt_glitch`=1 at START `last_edge` → IDLE next cycle. `cnt_en`=0, no `deser_en`, no `data_valid`. With `UART_RX_FRAME_ERR_EN`, `frame_err`=1 for one cycle.
- P=8, parity on, `par_err`=1 → IDLE, no `stp_chk_en`, no `data_valid`. Then `stp_err`=1 case → IDLE, no `data_valid`.
- Two back-to-back frames at P=32 with `rx_in`=0 during VALID → second START the next cycle. Two `data_valid` pulses 321 cycles apart.
- `rst` low mid-DATA (bit 4) → all outputs 0 immediately. After release with `rx_in`=1, the block stays IDLE. A new frame is then received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receiver slice.
//   rx_state_t     - frame-sequencer state encoding
//   START_BIT_IDX  - bit index of the start bit
//   LAST_DATA_IDX  - bit index of the last data bit (default data width)
//   PRESC_8/16/32  - legal oversampling ratios
//   is_counting()  - states in which the edge/bit counter runs
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    VALID
  } rx_state_t;

  localparam int unsigned START_BIT_IDX = 0;
  localparam int unsigned LAST_DATA_IDX = 8;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  function automatic logic is_counting(input rx_state_t st);
    return (st == START) || (st == DATA) || (st == PARITY) || (st == STOP);
  endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: frame-sequencing controller for the UART receiver.
// Detects the start condition, runs the edge/bit counter and pulses the
// per-bit enables for the sampler, deserializer and start/parity/stop
// checkers. data_valid pulses for one cycle per error-free frame.
//
// Ports:
//   clk, rst (async, active-low)
//   rx_in        synchronized serial line, idle high
//   par_en       parity bit present (latched at frame start)
//   prescale     oversampling ratio P (8, 16 or 32)
//   bit_cnt      bit index from the edge/bit counter
//   edge_cnt     edge index within the current bit
//   strt_glitch, par_err, stp_err  checker results
//   cnt_en, dat_samp_en            counter / sampler enables
//   deser_en, strt_chk_en, par_chk_en, stp_chk_en  per-bit strobes
//   data_valid   one-cycle good-frame pulse
//   frame_err    one-cycle abort pulse (only with UART_RX_FRAME_ERR_EN)
//
// Build option: define UART_RX_FRAME_ERR_EN to add the frame_err output.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W  = LAST_DATA_IDX,
  parameter int unsigned PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic               par_en,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [3:0]         bit_cnt,
  input  logic [4:0]         edge_cnt,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic               cnt_en,
  output logic               dat_samp_en,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic               frame_err
`endif
);

  localparam int unsigned CMP_W = PRESC_W + 1;

  rx_state_t state_q, state_d;
  logic      par_en_q, par_en_d;

  // One extra bit keeps prescale-1 from wrapping for any prescale value.
  logic [CMP_W-1:0] edge_ext, last_idx;
  logic             last_edge;

  assign edge_ext  = CMP_W'(edge_cnt);
  assign last_idx  = CMP_W'(prescale) - CMP_W'(1);
  assign last_edge = (edge_ext == last_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_en_q <= par_en_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    par_en_d    = par_en_q;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d  = START;
          par_en_d = par_en;
        end
      end
      START: begin
        if (last_edge) begin
          strt_chk_en = 1'b1;
          state_d     = strt_glitch ? IDLE : DATA;
        end
      end
      DATA: begin
        if (last_edge) begin
          deser_en = 1'b1;
          if (bit_cnt == 4'(DATA_W)) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (last_edge) begin
          par_chk_en = 1'b1;
          state_d    = par_err ? IDLE : STOP;
        end
      end
      STOP: begin
        if (last_edge) begin
          stp_chk_en = 1'b1;
          state_d    = stp_err ? IDLE : VALID;
        end
      end
      VALID: begin
        data_valid = 1'b1;
        // Back-to-back frame: a start bit already on the line skips IDLE.
        if (!rx_in) begin
          state_d  = START;
          par_en_d = par_en;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cnt_en      = is_counting(state_q);
  assign dat_samp_en = cnt_en;

`ifdef UART_RX_FRAME_ERR_EN
  assign frame_err = last_edge & (((state_q == START)  & strt_glitch) |
                                  ((state_q == PARITY) & par_err)     |
                                  ((state_q == STOP)   & stp_err));
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned PRESC_W = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               rx_in = 1'b1;
  logic               par_en = 1'b0;
  logic [PRESC_W-1:0] prescale = PRESC_W'(PRESC_8);
  logic [3:0]         bit_cnt;
  logic [4:0]         edge_cnt;
  logic               strt_glitch = 1'b0;
  logic               par_err = 1'b0;
  logic               stp_err = 1'b0;
  logic cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;
`ifdef UART_RX_FRAME_ERR_EN
  logic frame_err;
`endif

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  uart_rx_fsm #(.DATA_W(DATA_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
    .bit_cnt(bit_cnt), .edge_cnt(edge_cnt), .strt_glitch(strt_glitch),
    .par_err(par_err), .stp_err(stp_err), .cnt_en(cnt_en),
    .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid)
`ifdef UART_RX_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  // Edge/bit counter model: holds 0 while cnt_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!cnt_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (int'(edge_cnt) == int'(prescale) - 1) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 5'd1;
    end
  end

  // Event monitor, sampled on the inactive edge.
  int unsigned cyc = 0;
  int unsigned n_start = 0, n_deser = 0, n_strt = 0, n_par = 0, n_stp = 0, n_valid = 0, n_ferr = 0;
  int unsigned t_start = 0, t_valid = 0, t_valid_prev = 0, t_strt = 0, t_par = 0, t_stp = 0, t_fall = 0;
  logic cnt_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cnt_en && !cnt_prev) begin n_start = n_start + 1; t_start = cyc; end
    if (!cnt_en && cnt_prev) t_fall = cyc;
    cnt_prev = cnt_en;
    if (deser_en) n_deser = n_deser + 1;
    if (strt_chk_en) begin n_strt = n_strt + 1; t_strt = cyc; end
    if (par_chk_en) begin n_par = n_par + 1; t_par = cyc; end
    if (stp_chk_en) begin n_stp = n_stp + 1; t_stp = cyc; end
    if (data_valid) begin n_valid = n_valid + 1; t_valid_prev = t_valid; t_valid = cyc; end
`ifdef UART_RX_FRAME_ERR_EN
    if (frame_err) n_ferr = n_ferr + 1;
`endif
  end

  int unsigned b_start, b_deser, b_strt, b_par, b_stp, b_valid, b_ferr;

  task automatic snap();
    b_start = n_start; b_deser = n_deser; b_strt = n_strt; b_par = n_par;
    b_stp = n_stp; b_valid = n_valid; b_ferr = n_ferr;
  endtask

  // Start bit: line low for one sampled cycle.
  task automatic kick();
    @(posedge clk); #1 rx_in = 1'b0;
    @(posedge clk); #1 rx_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid} !== 7'b0)
      $display("FAIL reset_outputs got=%b exp=0000000", {cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid});
    else pass_cnt++;
`ifdef UART_RX_FRAME_ERR_EN
    total_cnt++;
    if (frame_err !== 1'b0) $display("FAIL reset_frame_err got=%b exp=0", frame_err); else pass_cnt++;
`endif
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total_cnt++;
    if (cnt_en !== 1'b0) $display("FAIL reset_idle_cnt_en got=%b exp=0", cnt_en); else pass_cnt++;
  endtask

  task automatic test_no_parity();
    snap();
    prescale = PRESC_W'(PRESC_8); par_en = 1'b0;
    kick();
    repeat (20) @(posedge clk);
    #1 par_en = 1'b1; // mid-frame change must be ignored
    repeat (65) @(posedge clk);
    #1 par_en = 1'b0;
    total_cnt++;
    if (n_deser - b_deser != 8) $display("FAIL np_deser_count got=%0d exp=8", n_deser - b_deser); else pass_cnt++;
    total_cnt++;
    if (n_strt - b_strt != 1) $display("FAIL np_strt_count got=%0d exp=1", n_strt - b_strt); else pass_cnt++;
    total_cnt++;
    if (n_par - b_par != 0) $display("FAIL np_par_count got=%0d exp=0", n_par - b_par); else pass_cnt++;
    total_cnt++;
    if (n_stp - b_stp != 1) $display("FAIL np_stp_count got=%0d exp=1", n_stp - b_stp); else pass_cnt++;
    total_cnt++;
    if (n_valid - b_valid != 1) $display("FAIL np_valid_count got=%0d exp=1", n_valid - b_valid); else pass_cnt++;
    total_cnt++;
    if (t_valid - t_start != 80) $display("FAIL np_valid_time got=%0d exp=80", t_valid - t_start); else pass_cnt++;
    total_cnt++;
    if (t_strt - t_start != 7) $display("FAIL np_strt_time got=%0d exp=7", t_strt - t_start); else pass_cnt++;
    total_cnt++;
    if (t_stp - t_start != 79) $display("FAIL np_stp_time got=%0d exp=79", t_stp - t_start); else pass_cnt++;
    total_cnt++;
    if (cnt_en !== 1'b0) $display("FAIL np_idle_after got=%b exp=0", cnt_en); else pass_cnt++;
`ifdef UART_RX_FRAME_ERR_EN
    total_cnt++;
    if (n_ferr - b_ferr != 0) $display("FAIL np_frame_err got=%0d exp=0", n_ferr - b_ferr); else pass_cnt++;
`endif
  endtask

  task automatic test_parity();
    snap();
    prescale = PRESC_W'(PRESC_16); par_en = 1'b1;
    kick();
    par_en = 1'b0; // latched at start; the frame still carries parity
    repeat (180) @(posedge clk);
    #1;
    total_cnt++;
    if (n_par - b_par != 1) $display("FAIL par_count got=%0d exp=1", n_par - b_par); else pass_cnt++;
    total_cnt++;
    if (t_par - t_start != 159) $display("FAIL par_time got=%0d exp=159", t_par - t_start); else pass_cnt++;
    total_cnt++;
    if (t_valid - t_start != 176) $display("FAIL par_valid_time got=%0d exp=176", t_valid - t_start); else pass_cnt++;
    total_cnt++;
    if (n_valid - b_valid != 1) $display("FAIL par_valid_count got=%0d exp=1", n_valid - b_valid); else pass_cnt++;
    total_cnt++;
    if (n_deser - b_deser != 8) $display("FAIL par_deser_count got=%0d exp=8", n_deser - b_deser); else pass_cnt++;
  endtask

  task automatic test_start_glitch();
    snap();
    prescale = PRESC_W'(PRESC_8); par_en = 1'b0; strt_glitch = 1'b1;
    kick();
    repeat (90) @(posedge clk);
    #1 strt_glitch = 1'b0;
    total_cnt++;
    if (n_strt - b_strt != 1) $display("FAIL glitch_strt_count got=%0d exp=1", n_strt - b_strt); else pass_cnt++;
    total_cnt++;
    if (t_fall - t_strt != 1) $display("FAIL glitch_idle_next got=%0d exp=1", t_fall - t_strt); else pass_cnt++;
    total_cnt++;
    if (n_deser - b_deser != 0) $display("FAIL glitch_deser got=%0d exp=0", n_deser - b_deser); else pass_cnt++;
    total_cnt++;
    if (n_valid - b_valid != 0) $display("FAIL glitch_valid got=%0d exp=0", n_valid - b_valid); else pass_cnt++;
    total_cnt++;
    if (cnt_en !== 1'b0) $display("FAIL glitch_cnt_en got=%b exp=0", cnt_en); else pass_cnt++;
`ifdef UART_RX_FRAME_ERR_EN
    total_cnt++;
    if (n_ferr - b_ferr != 1) $display("FAIL glitch_frame_err got=%0d exp=1", n_ferr - b_ferr); else pass_cnt++;
`endif
  endtask

  task automatic test_errors();
    snap();
    prescale = PRESC_W'(PRESC_8); par_en = 1'b1; par_err = 1'b1;
    kick();
    repeat (95) @(posedge clk);
    #1 par_err = 1'b0; par_en = 1'b0;
    total_cnt++;
    if (n_par - b_par != 1) $display("FAIL perr_par_count got=%0d exp=1", n_par - b_par); else pass_cnt++;
    total_cnt++;
    if (n_stp - b_stp != 0) $display("FAIL perr_stp_count got=%0d exp=0", n_stp - b_stp); else pass_cnt++;
    total_cnt++;
    if (n_valid - b_valid != 0) $display("FAIL perr_valid got=%0d exp=0", n_valid - b_valid); else pass_cnt++;
    total_cnt++;
    if (t_fall - t_par != 1) $display("FAIL perr_idle_next got=%0d exp=1", t_fall - t_par); else pass_cnt++;
`ifdef UART_RX_FRAME_ERR_EN
    total_cnt++;
    if (n_ferr - b_ferr != 1) $display("FAIL perr_frame_err got=%0d exp=1", n_ferr - b_ferr); else pass_cnt++;
`endif
    snap();
    stp_err = 1'b1;
    kick();
    repeat (90) @(posedge clk);
    #1 stp_err = 1'b0;
    total_cnt++;
    if (n_stp - b_stp != 1) $display("FAIL serr_stp_count got=%0d exp=1", n_stp - b_stp); else pass_cnt++;
    total_cnt++;
    if (n_valid - b_valid != 0) $display("FAIL serr_valid got=%0d exp=0", n_valid - b_valid); else pass_cnt++;
    total_cnt++;
    if (t_fall - t_stp != 1) $display("FAIL serr_idle_next got=%0d exp=1", t_fall - t_stp); else pass_cnt++;
`ifdef UART_RX_FRAME_ERR_EN
    total_cnt++;
    if (n_ferr - b_ferr != 1) $display("FAIL serr_frame_err got=%0d exp=1", n_ferr - b_ferr); else pass_cnt++;
`endif
  endtask

  task automatic test_back_to_back();
    snap();
    prescale = PRESC_W'(PRESC_32); par_en = 1'b0;
    kick();
    repeat (320) @(posedge clk);
    #1 rx_in = 1'b0; // line low during the VALID cycle
    @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (330) @(posedge clk);
    #1;
    total_cnt++;
    if (n_valid - b_valid != 2) $display("FAIL b2b_valid_count got=%0d exp=2", n_valid - b_valid); else pass_cnt++;
    total_cnt++;
    if (t_valid - t_valid_prev != 321) $display("FAIL b2b_valid_gap got=%0d exp=321", t_valid - t_valid_prev); else pass_cnt++;
    total_cnt++;
    if (n_start - b_start != 2) $display("FAIL b2b_start_count got=%0d exp=2", n_start - b_start); else pass_cnt++;
    total_cnt++;
    if (t_start - t_valid_prev != 1) $display("FAIL b2b_restart got=%0d exp=1", t_start - t_valid_prev); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    snap();
    prescale = PRESC_W'(PRESC_8); par_en = 1'b0;
    kick();
    repeat (34) @(posedge clk);
    #1;
    total_cnt++;
    if ({cnt_en, dat_samp_en} !== 2'b11) $display("FAIL mid_running got=%b exp=11", {cnt_en, dat_samp_en}); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid} !== 7'b0)
      $display("FAIL mid_reset_outputs got=%b exp=0000000", {cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid});
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total_cnt++;
    if (cnt_en !== 1'b0) $display("FAIL mid_stays_idle got=%b exp=0", cnt_en); else pass_cnt++;
    total_cnt++;
    if (n_start - b_start != 1) $display("FAIL mid_no_restart got=%0d exp=1", n_start - b_start); else pass_cnt++;
    total_cnt++;
    if (n_valid - b_valid != 0) $display("FAIL mid_no_valid got=%0d exp=0", n_valid - b_valid); else pass_cnt++;
    snap();
    kick();
    repeat (85) @(posedge clk);
    #1;
    total_cnt++;
    if (n_valid - b_valid != 1) $display("FAIL post_valid_count got=%0d exp=1", n_valid - b_valid); else pass_cnt++;
    total_cnt++;
    if (t_valid - t_start != 80) $display("FAIL post_valid_time got=%0d exp=80", t_valid - t_start); else pass_cnt++;
    total_cnt++;
    if (n_deser - b_deser != 8) $display("FAIL post_deser_count got=%0d exp=8", n_deser - b_deser); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_start_glitch();
    test_errors();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
